// File: rtl/mandelbrot_pkg.sv
// ---------------------------------------------------------------------------
// mandelbrot_pkg
// Shared types and helpers for the Mandelbrot escape-time engine.
//   state_e        : controller states (IDLE / ITER / DONE)
//   esc_threshold  : escape radius squared (4.0) expressed with q fractional bits
// ---------------------------------------------------------------------------
package mandelbrot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  // 4.0 in fixed point with q fractional bits.
  function automatic int unsigned esc_threshold(input int unsigned q);
    return 32'd4 << q;
  endfunction

endpackage

// File: rtl/mandelbrot_engine_if.sv
// ---------------------------------------------------------------------------
// mandelbrot_engine_if
// Job/result handshake bundle between a coordinate source, the engine and a
// result consumer.
//   in_valid/in_ready   : point request handshake
//   c_real/c_imag       : signed fixed-point point c
//   out_valid/out_ready : result handshake
//   count/escaped       : escape iteration index and escape flag
// master = source/consumer side, slave = engine side.
// ---------------------------------------------------------------------------
interface mandelbrot_engine_if #(
  parameter int N     = 16,
  parameter int CNT_W = 8
);

  logic                 in_valid;
  logic                 in_ready;
  logic signed [N-1:0]  c_real;
  logic signed [N-1:0]  c_imag;
  logic                 out_valid;
  logic                 out_ready;
  logic [CNT_W-1:0]     count;
  logic                 escaped;

  modport master (
    output in_valid, c_real, c_imag, out_ready,
    input  in_ready, out_valid, count, escaped
  );

  modport slave (
    input  in_valid, c_real, c_imag, out_ready,
    output in_ready, out_valid, count, escaped
  );

endinterface

// File: rtl/mandelbrot_engine_fx_mul.sv
// ---------------------------------------------------------------------------
// fx_mul
// Signed N x N fixed-point multiply followed by an arithmetic (flooring)
// right shift of SHIFT bits, result kept in OUT_W bits.
//   a_i, b_i : signed N-bit operands
//   p_o      : (a_i * b_i) >>> SHIFT, truncated/extended to OUT_W bits
// ---------------------------------------------------------------------------
module fx_mul #(
  parameter int Q     = 12,
  parameter int N     = 16,
  parameter int SHIFT = Q,
  parameter int OUT_W = 2 * N
) (
  input  logic signed [N-1:0]     a_i,
  input  logic signed [N-1:0]     b_i,
  output logic signed [OUT_W-1:0] p_o
);

  logic signed [2*N-1:0] prod_s;

  assign prod_s = a_i * b_i;
  assign p_o    = OUT_W'(prod_s >>> SHIFT);

endmodule

// File: rtl/mandelbrot_engine.sv
// ---------------------------------------------------------------------------
// mandelbrot_engine
// Escape-time iterator: accepts c, runs z <- z^2 + c from z = 0 at one
// iteration per clock, reports the escape index (or MAX_ITER) and a flag.
//   CLK   : rising-edge clock
//   RST_N : asynchronous active-low reset, aborts any job in flight
//   bus   : slave side of mandelbrot_engine_if (request + result handshakes)
// All handshake outputs are driven straight from flops.
// ---------------------------------------------------------------------------
module mandelbrot_engine
  import mandelbrot_pkg::*;
#(
  parameter int Q        = 12,
  parameter int N        = 16,
  parameter int MAX_ITER = 255,
  parameter int CNT_W    = $clog2(MAX_ITER + 1)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  mandelbrot_engine_if.slave   bus
);

  if (N - Q < 4) begin : g_range_chk
    $error("mandelbrot_engine: N-Q must be at least 4");
  end
  if (MAX_ITER < 1) begin : g_iter_chk
    $error("mandelbrot_engine: MAX_ITER must be at least 1");
  end

  // Squares are non-negative, so the sum never exceeds 2N+1 signed bits.
  localparam logic signed [2*N:0]  ESC_TH = (2*N+1)'(esc_threshold(Q));
  localparam logic [CNT_W-1:0]     LAST_K = CNT_W'(MAX_ITER - 1);
  localparam logic [CNT_W-1:0]     MAX_K  = CNT_W'(MAX_ITER);

  state_e                state_q, state_d;
  logic signed [N-1:0]   cr_q, cr_d, ci_q, ci_d;
  logic signed [N-1:0]   zr_q, zr_d, zi_q, zi_d;
  logic [CNT_W-1:0]      k_q, k_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  escaped_q, escaped_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;

  logic signed [2*N-1:0] zr2_s, zi2_s;
  logic signed [N-1:0]   zri_s;
  logic signed [2*N:0]   mag_s;
  logic                  escape_s;
  logic signed [N-1:0]   zr_next_s, zi_next_s;

  fx_mul #(.Q(Q), .N(N), .SHIFT(Q),   .OUT_W(2*N)) u_mul_rr (.a_i(zr_q), .b_i(zr_q), .p_o(zr2_s));
  fx_mul #(.Q(Q), .N(N), .SHIFT(Q),   .OUT_W(2*N)) u_mul_ii (.a_i(zi_q), .b_i(zi_q), .p_o(zi2_s));
  // Shifting by Q-1 folds the factor 2 of 2*zr*zi into the multiplier.
  fx_mul #(.Q(Q), .N(N), .SHIFT(Q-1), .OUT_W(N))   u_mul_ri (.a_i(zr_q), .b_i(zi_q), .p_o(zri_s));

  // Magnitude kept wide so a large z (up to the full +-8 range) cannot wrap below the threshold.
  assign mag_s     = {zr2_s[2*N-1], zr2_s} + {zi2_s[2*N-1], zi2_s};
  assign escape_s  = (mag_s > ESC_TH);
  assign zr_next_s = zr2_s[N-1:0] - zi2_s[N-1:0] + cr_q;
  assign zi_next_s = zri_s + ci_q;

  // Next-state and datapath update logic.
  always_comb begin
    state_d     = state_q;
    cr_d        = cr_q;
    ci_d        = ci_q;
    zr_d        = zr_q;
    zi_d        = zi_q;
    k_d         = k_q;
    count_d     = count_q;
    escaped_d   = escaped_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          cr_d       = bus.c_real;
          ci_d       = bus.c_imag;
          zr_d       = {N{1'b0}};
          zi_d       = {N{1'b0}};
          k_d        = {CNT_W{1'b0}};
          in_ready_d = 1'b0;
          state_d    = ITER;
        end else begin
          state_d    = IDLE;
        end
      end
      ITER: begin
        if (escape_s) begin
          count_d     = k_q;
          escaped_d   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (k_q == LAST_K) begin
          count_d     = MAX_K;
          escaped_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          zr_d        = zr_next_s;
          zi_d        = zi_next_s;
          k_d         = k_q + CNT_W'(1'b1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d     = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cr_q        <= {N{1'b0}};
      ci_q        <= {N{1'b0}};
      zr_q        <= {N{1'b0}};
      zi_q        <= {N{1'b0}};
      k_q         <= {CNT_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      escaped_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cr_q        <= cr_d;
      ci_q        <= ci_d;
      zr_q        <= zr_d;
      zi_q        <= zi_d;
      k_q         <= k_d;
      count_q     <= count_d;
      escaped_q   <= escaped_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.count     = count_q;
  assign bus.escaped   = escaped_q;

endmodule
